// File: rtl/fma16_wb.sv
// fma16_wb: FMA writeback FIFO (result/flags/tag) with sticky fflags; FMA16_WB_CANON_NAN_EN stores NaNs as 16'h7E00
module fma16_wb #(
  parameter int TAGW  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_result,
  input  logic [3:0]               in_flags,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic [3:0]               out_flags,
  output logic [TAGW-1:0]          out_tag,
  output logic [3:0]               fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]     res_mem  [DEPTH];
  logic [3:0]      flag_mem [DEPTH];
  logic [TAGW-1:0] tag_mem  [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop;
  logic [15:0]     store_res;
  assign in_ready  = count != (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
`ifdef FMA16_WB_CANON_NAN_EN
  assign store_res = (&in_result[14:10] && |in_result[9:0]) ? 16'h7E00 : in_result;
`else
  assign store_res = in_result;
`endif
  assign out_result = out_valid ? res_mem[rptr]  : '0;
  assign out_flags  = out_valid ? flag_mem[rptr] : '0;
  assign out_tag    = out_valid ? tag_mem[rptr]  : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      fflags <= '0;
    end else begin
      wptr   <= wptr + AW'(push);
      rptr   <= rptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      fflags <= (fflags_clr ? 4'b0 : fflags) | (push ? in_flags : 4'b0);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wptr]  <= store_res;
      flag_mem[wptr] <= in_flags;
      tag_mem[wptr]  <= in_tag;
    end
  end
endmodule

// File: tb/tb_fma16_wb.sv
// tb_fma16_wb: scoreboard bench for fma16_wb with directed vectors
module tb_fma16_wb;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
    logic [3:0]  tag;
  } item_t;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0, fflags_clr = 0;
  logic [15:0] in_result = 0, out_result;
  logic [3:0]  in_flags = 0, out_flags, in_tag = 0, out_tag, fflags;
  logic [2:0]  count;
  item_t       q[$];
  int          total = 0, bad = 0, mcnt = 0;
  logic [3:0]  mfl = 0;
  fma16_wb #(.TAGW(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag), .fflags(fflags),
    .fflags_clr(fflags_clr), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  function automatic logic [15:0] exp_res(logic [15:0] r);
`ifdef FMA16_WB_CANON_NAN_EN
    return (r[14:10] == 5'h1F && r[9:0] != 0) ? 16'h7E00 : r;
`else
    return r;
`endif
  endfunction
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out got=%h exp=none", out_result);
      end else begin
        item_t e;
        e = q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_flags", out_flags, e.fl);
        chk("out_tag", out_tag, e.tag);
      end
    end
  end
  task automatic state_chk();
    chk("count", count, mcnt);
    chk("fflags", fflags, mfl);
    chk("in_ready", in_ready, mcnt != DEPTH);
    chk("out_valid", out_valid, mcnt != 0);
    if (mcnt == 0) chk("out_zero", {out_result, out_flags, out_tag}, 0);
  endtask
  task automatic drive(logic v, logic [15:0] r, logic [3:0] f, logic [3:0] t, logic rdy, logic clr);
    logic acc;
    @(posedge clk);
    #1;
    state_chk();
    reset = 0;
    in_valid = v; in_result = r; in_flags = f; in_tag = t;
    out_ready = rdy; fflags_clr = clr;
    acc = v && mcnt < DEPTH;
    if (acc) q.push_back('{exp_res(r), f, t});
    mcnt = mcnt + int'(acc) - int'(rdy && mcnt > 0);
    mfl = (clr ? 4'b0 : mfl) | (acc ? f : 4'b0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1; in_valid = 0; out_ready = 0; fflags_clr = 0;
    mcnt = 0; mfl = 0; q.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    drive(0, 16'h0, 4'h0, 4'h0, 0, 0);
    drive(1, 16'h3C00, 4'b0000, 4'd1, 1, 0);
    drive(0, 16'h1234, 4'hF, 4'hF, 1, 0);
    drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    drive(1, 16'h1000, 4'b0001, 4'd0, 0, 0);
    drive(1, 16'h1001, 4'b0100, 4'd1, 0, 0);
    drive(1, 16'h1002, 4'b0000, 4'd2, 0, 0);
    drive(1, 16'h1003, 4'b0000, 4'd3, 0, 0);
    drive(1, 16'h2222, 4'b0010, 4'd4, 0, 0);
    drive(1, 16'h2223, 4'b0010, 4'd4, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    drive(1, 16'h4000, 4'h0, 4'd5, 0, 0);
    drive(1, 16'h4001, 4'h0, 4'd6, 0, 0);
    for (int i = 0; i < 10; i++)
      drive(1, 16'h5000 + 16'(i), (i == 4) ? 4'b1000 : 4'b0000, 4'(7 + i), 1, i == 4);
    drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    drive(1, 16'h6000, 4'b0011, 4'd1, 0, 0);
    drive(1, 16'h6001, 4'b0000, 4'd2, 0, 0);
    drive(1, 16'h6002, 4'b0000, 4'd3, 0, 0);
    drive(0, 16'h0, 4'h0, 4'h0, 0, 0);
    do_reset();
    drive(1, 16'h7BFF, 4'b0001, 4'd9, 1, 0);
    drive(1, 16'hFE05, 4'b1000, 4'd10, 1, 0);
    drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    drive(0, 16'h0, 4'h0, 4'h0, 1, 0);
    @(posedge clk);
    #1;
    state_chk();
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fma16_wb.md
Name: fma16_wb

Overview:
- Writeback/result-buffer stage directly downstream of the combinational half-precision FMA unit.
- Captures each 16-bit result and its 4-bit exception flags, tagged by the issuing sequencer, into a small FIFO.
- Presents entries to the consumer (register file / testbench checker) over a valid/ready handshake.
- Maintains a sticky, software-clearable accumulated flag register (fflags-style).

Parameters:
- TAGW, 4, width of the request tag carried alongside each result.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  FMA result and flags valid this cycle
- in_ready  output  1  stage can accept; equals not full
- in_result  input  16  FMA result (binary16)
- in_flags  input  4  {invalid, overflow, underflow, inexact}
- in_tag  input  TAGW  request tag
- out_valid  output  1  head entry valid; equals not empty
- out_ready  input  1  consumer accepts head entry
- out_result  output  16  head result
- out_flags  output  4  head flags
- out_tag  output  TAGW  head tag
- fflags  output  4  sticky OR of flags of all accepted results
- fflags_clr  input  1  clear sticky flags
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: count=0, out_valid=0, in_ready=1, fflags=0, read/write pointers=0. out_result, out_flags and out_tag are driven to 0 while empty. Reset mid-traffic discards all entries the same cycle.
- Push: in_valid && in_ready at the edge writes the entry at wptr; wptr increments modulo DEPTH.
- Pop: out_valid && out_ready at the edge; rptr increments modulo DEPTH.
- Output timing:
  - out_* reads the entry at rptr combinationally from FIFO storage; no bypass.
  - A pushed entry is visible on out_* one cycle after the push.
  - Latency in to out: 1 cycle minimum.
- Occupancy:
  - Push only: count+1. Pop only: count-1. Both, or neither: unchanged.
  - Full (count==DEPTH): in_ready=0; in_valid is ignored with no state change, and the upstream holds.
  - Full with pop and in_valid: in_ready is still 0, so no push that cycle. There is no same-cycle full pass-through.
  - Empty with in_valid and out_ready: push only; the entry appears next cycle.
- Pointers: $clog2(DEPTH) bits; wrap naturally. Full/empty are derived from count, not from pointer compare.
- Sticky flags:
  - Next fflags = (fflags_clr ? 0 : fflags) | (push ? in_flags : 0).
  - A same-cycle clear and push leaves only the new flags.
  - Flags of a rejected input (not pushed) are never accumulated.
- Output stability: out_result, out_flags and out_tag stay stable while out_valid=1 and out_ready=0.
- State machine: none beyond the occupancy counter. States EMPTY (count=0), PARTIAL, FULL (count=DEPTH), with transitions per the push/pop rules above.

Optional Feature:
- Macro: FMA16_WB_CANON_NAN_EN.
- Defined:
  - Any pushed in_result with exponent 5'h1F and nonzero fraction is stored as canonical quiet NaN 16'h7E00.
  - Sign and payload are discarded.
  - Flags and tag are stored unchanged.
- Undefined: results are stored bit-exact.
- The input handshake and latency are identical in both builds.

Test Plan:
- Reset, then a single push {16'h3C00, 4'b0000, tag 1} with out_ready=1:
  - out_valid=1 exactly one cycle later with out_result=16'h3C00, out_tag=1.
  - count returns to 0 after the pop; fflags=0.
- Fill to full, DEPTH=4, with out_ready=0: push tags 0..3.
  - in_ready=0 after the 4th push and count=4.
  - A 5th in_valid (tag 4) is dropped; popping 4 yields tags 0,1,2,3 in order.
- Simultaneous push and pop at count=2 for 10 cycles: count stays 2, order preserved, pointers wrap past DEPTH with no loss.
- Sticky flags:
  - Push flags 4'b0001 then 4'b0100: fflags=4'b0101.
  - fflags_clr with a push of 4'b1000 in the same cycle: fflags=4'b1000.
  - A rejected push (full) of 4'b0010 leaves fflags unchanged.
- Reset asserted with count=3: next cycle count=0, out_valid=0, in_ready=1, fflags=0; the next push is output correctly.
- With FMA16_WB_CANON_NAN_EN: push 16'hFE05 -> out_result=16'h7E00. Without the macro -> out_result=16'hFE05.
